// File: rtl/status_flag_sequencer.sv
// rtl/status_flag_sequencer.sv - FIFO-buffered, one-hot command driver for the carry/zero status register
module status_flag_sequencer #(
  parameter int DEPTH     = 4,
  parameter int INIT_SYNC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic [2:0]             req_op,
  input  logic                   req_c,
  input  logic                   req_z,
  output logic                   req_ready,
  input  logic                   ovf_clr,
  output logic                   SRload,
  output logic                   Cin,
  output logic                   Zin,
  output logic                   Cset,
  output logic                   Creset,
  output logic                   Zset,
  output logic                   Zreset,
  output logic                   c_shadow,
  output logic                   z_shadow,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_LOAD    = 3'd1;
  localparam logic [2:0] OP_CSET    = 3'd2;
  localparam logic [2:0] OP_CRESET  = 3'd3;
  localparam logic [2:0] OP_ZSET    = 3'd4;
  localparam logic [2:0] OP_ZRESET  = 3'd5;
  localparam logic [2:0] OP_CLR_ALL = 3'd6;
  localparam logic [2:0] OP_SET_ALL = 3'd7;

  typedef enum logic [1:0] {INIT_C, INIT_Z, RUN, SECOND} state_t;

  state_t        state, state_nx;
  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          second_set;
  logic          full, empty, push, pop;
  logic [2:0]    head_op;
  logic          head_c, head_z;
  logic          srload_d, cin_d, zin_d, cset_d, creset_d, zset_d, zreset_d;

  assign full      = (level == FULL_LVL);
  assign empty     = (level == '0);
  assign req_ready = ((state == RUN) || (state == SECOND)) && !full;
  assign push      = req_valid && req_ready && (req_op != OP_NOP);
  assign pop       = (state == RUN) && !empty;
  assign busy      = !empty || (state != RUN);
  assign {head_op, head_c, head_z} = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {req_op, req_c, req_z};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
      // a stall on the same edge as a clear keeps the flag set
      ovf <= (req_valid && !req_ready) || (ovf && !ovf_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= (INIT_SYNC != 0) ? INIT_C : RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      INIT_C:  state_nx = INIT_Z;
      INIT_Z:  state_nx = RUN;
      RUN:     if (pop && ((head_op == OP_CLR_ALL) || (head_op == OP_SET_ALL))) state_nx = SECOND;
      SECOND:  state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    {srload_d, cin_d, zin_d, cset_d, creset_d, zset_d, zreset_d} = '0;
    case (state)
      INIT_C: creset_d = 1'b1;
      INIT_Z: zreset_d = 1'b1;
      RUN: if (pop) begin
        case (head_op)
          OP_LOAD: begin
            srload_d = 1'b1;
            cin_d    = head_c;
            zin_d    = head_z;
          end
          OP_CSET, OP_SET_ALL:   cset_d   = 1'b1;
          OP_CRESET, OP_CLR_ALL: creset_d = 1'b1;
          OP_ZSET:               zset_d   = 1'b1;
          OP_ZRESET:             zreset_d = 1'b1;
          default: ;
        endcase
      end
      SECOND: begin
        if (second_set) zset_d   = 1'b1;
        else            zreset_d = 1'b1;
      end
      default: ;
    endcase
  end

  // shadows follow the command being registered on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {SRload, Cin, Zin, Cset, Creset, Zset, Zreset} <= '0;
      c_shadow   <= 1'b0;
      z_shadow   <= 1'b0;
      second_set <= 1'b0;
    end else begin
      SRload <= srload_d;
      Cin    <= cin_d;
      Zin    <= zin_d;
      Cset   <= cset_d;
      Creset <= creset_d;
      Zset   <= zset_d;
      Zreset <= zreset_d;
      if (srload_d) begin
        c_shadow <= cin_d;
        z_shadow <= zin_d;
      end
      if (cset_d)   c_shadow <= 1'b1;
      if (creset_d) c_shadow <= 1'b0;
      if (zset_d)   z_shadow <= 1'b1;
      if (zreset_d) z_shadow <= 1'b0;
      if (pop) second_set <= (head_op == OP_SET_ALL);
    end
  end

endmodule

// File: doc/status_flag_sequencer.md
Name: status_flag_sequencer

Overview:
- Command-side driver for the datapath status register, which holds the carry and zero flags.
- Accepts flag-update requests from the controller/ALU through a valid/ready handshake and buffers them in a small FIFO.
- Issues exactly one mutually exclusive command per clock on SRload/Cset/Creset/Zset/Zreset/Cin/Zin, so the register's priority chain never discards a request.
- Keeps shadow copies of C and Z that mirror the register contents, and can force the register to a known state after reset.

Parameters:
- DEPTH, 4: request FIFO entries; power of 2, minimum 2.
- INIT_SYNC, 1: when 1, issue Creset then Zreset automatically after reset release.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_op  in  3  0 NOP, 1 LOAD, 2 CSET, 3 CRESET, 4 ZSET, 5 ZRESET, 6 CLR_ALL, 7 SET_ALL.
- req_c  in  1  carry value for LOAD.
- req_z  in  1  zero value for LOAD.
- req_ready  out  1  request can be accepted this cycle.
- ovf_clr  in  1  clears ovf.
- SRload  out  1  load command to the status register.
- Cin  out  1  carry data for the load.
- Zin  out  1  zero data for the load.
- Cset, Creset, Zset, Zreset  out  1 each  single-flag commands.
- c_shadow, z_shadow  out  1 each  expected register flag values.
- level  out  log2(DEPTH)+1  FIFO occupancy.
- busy  out  1  FIFO not empty, or FSM not in RUN.
- ovf  out  1  sticky: req_valid was high while req_ready was low.

Behaviour:
- Reset (async, rst_n=0):
  - All command outputs, c_shadow, z_shadow, ovf and level go to 0 immediately.
  - FIFO is flushed.
  - State becomes INIT_C if INIT_SYNC=1, else RUN.
  - Applies equally mid-operation, including in SECOND state; a half-issued compound op is abandoned.
- Command outputs:
  - Registered and high for exactly one clk cycle.
  - At most one of SRload/Cset/Creset/Zset/Zreset is high in any cycle.
  - Cin/Zin are 0 whenever SRload=0.
  - The status register samples on the falling edge, mid-cycle.
- Handshake:
  - A transfer occurs at a rising edge with req_valid=1 and req_ready=1.
  - req_ready = (state is RUN or SECOND) and FIFO not full; it is combinational from registered state only.
  - A push is refused when full, even if a pop happens on the same edge.
  - NOP transfers are accepted and dropped: no FIFO write, no command.
  - req_valid=1 with req_ready=0 sets ovf; it stays set until ovf_clr=1 at an edge. If set and clear occur on the same edge, set wins.
- FSM states and transitions:
  - INIT_C: drive Creset for one cycle, then go to INIT_Z.
  - INIT_Z: drive Zreset for one cycle, then go to RUN.
  - RUN, FIFO non-empty: pop the head and drive its command.
    - LOAD: SRload=1, Cin=req_c, Zin=req_z.
    - CSET/CRESET/ZSET/ZRESET: the single matching line.
    - CLR_ALL: Creset this cycle; SET_ALL: Cset this cycle. Either one then moves to SECOND.
  - RUN, FIFO empty: all command outputs 0.
  - SECOND: drive Zreset (CLR_ALL) or Zset (SET_ALL) with no pop, then return to RUN.
- Latency:
  - A request accepted at edge N into an empty FIFO in RUN is popped at edge N+1.
  - Its command is high from edge N+1 to edge N+2.
  - Sustained throughput is 1 command/cycle; compound ops take 2 cycles.
- Shadows:
  - Update on the same edge the command is registered: LOAD copies c/z; set/reset forces 1/0.
  - INIT_C/INIT_Z clear them; they are already 0 from reset.
- FIFO:
  - Circular read/write pointers of width log2(DEPTH); both wrap modulo DEPTH.
  - level = writes − pops and never exceeds DEPTH.
  - A push and a pop on the same edge leave level unchanged.

Test Plan:
- Reset release, INIT_SYNC=1: Creset high in cycle 1, Zreset high in cycle 2, req_ready=0 for both cycles then 1; c_shadow=z_shadow=0; no other command line ever high.
- Single LOAD (c=1, z=0) into an idle FIFO at edge N: SRload=1, Cin=1, Zin=0 between edges N+1 and N+2; c_shadow=1, z_shadow=0; level goes 1 then 0.
- SET_ALL followed immediately by CRESET: sequence is Cset, then Zset, then Creset on consecutive cycles; shadows end at c=0, z=1; the one-hot check holds every cycle.
- Six back-to-back SET_ALL with req_valid held, DEPTH=4:
  - level reaches 4 and req_ready drops.
  - Stalled requests set ovf; ovf_clr=1 clears it.
  - All accepted ops are issued in order and pointers wrap correctly.
- Assert rst_n=0 asynchronously while in SECOND with level=3: outputs and level read 0 before the next edge; the pending Zset never appears; the INIT sequence restarts after release.
- NOP with req_valid=1 in RUN: accepted (req_ready=1), level unchanged, no command issued, busy stays 0.
